// File: rtl/karat_mult_arbiter_if.sv
// karat_mult_arbiter_if: requester, response and multiplier signals of the shared-multiplier arbiter
interface karat_mult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int wI   = 1024,
    parameter int wO   = 2 * wI,
    parameter int wID  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*wI-1:0] req_x;
    logic [NREQ*wI-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [wID-1:0]     rsp_id;
    logic [wO-1:0]      rsp_o;
    logic [wI-1:0]      mul_iX;
    logic [wI-1:0]      mul_iY;
    logic               mul_enable;
    logic               mul_finish;
    logic [wO-1:0]      mul_oO;
    logic               busy;
    logic               err_timeout;
    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, mul_finish, mul_oO,
        output req_ready, rsp_valid, rsp_id, rsp_o, mul_iX, mul_iY, mul_enable, busy, err_timeout
    );
    modport master (
        output req_valid, req_x, req_y, rsp_ready, mul_finish, mul_oO,
        input  req_ready, rsp_valid, rsp_id, rsp_o, mul_iX, mul_iY, mul_enable, busy, err_timeout
    );
endinterface

// File: rtl/karat_mult_arbiter.sv
// karat_mult_arbiter: round-robin sharing of one multiplier among NREQ requesters,
// one operation in flight, tagged response with a sticky finish timeout.
module karat_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int wI   = 1024,
    parameter int wO   = 2 * wI,
    parameter int wID  = $clog2(NREQ),
    parameter int TMO  = 64
) (
    input logic clk,
    input logic rst,
    karat_mult_arbiter_if.slave bus
);
    localparam int CW = $clog2(TMO + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e         state_q, state_d;
    logic [wID-1:0] rr_q, rr_d, id_q, id_d, gnt;
    logic [wI-1:0]  x_q, x_d, y_q, y_d;
    logic [wO-1:0]  p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d, found;
    // Lowest rotated offset from rr_q wins, so scan offsets from the top down.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(rr_q) + i) % NREQ]) begin
                found = 1'b1;
                gnt   = wID'((int'(rr_q) + i) % NREQ);
            end
        end
    end
    assign bus.req_ready   = (state_q == IDLE && found && !rst) ? NREQ'(1) << gnt : '0;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_o       = p_q;
    assign bus.mul_iX      = x_q;
    assign bus.mul_iY      = y_q;
    assign bus.mul_enable  = state_q == ISSUE;
    assign bus.busy        = state_q != IDLE;
    assign bus.err_timeout = err_q;
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found) begin
                x_d     = bus.req_x[int'(gnt)*wI +: wI];
                y_d     = bus.req_y[int'(gnt)*wI +: wI];
                id_d    = gnt;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mul_finish) begin
                    p_d     = bus.mul_oO;
                    state_d = RESP;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    p_d     = '0;
                    state_d = RESP;
                end
            end
            RESP: if (bus.rsp_ready) begin
                rr_d    = wID'((int'(id_q) + 1) % NREQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule
